// File: rtl/image_row_loader.sv
// Assembles a raster-order pixel stream into a full IMG_DIM x IMG_DIM image buffer,
// then scans the rows out one at a time through a registered row select.
module image_row_loader #(
  parameter int PIX_BIT = 10,
  parameter int IMG_DIM = 28,
  parameter int SEL_BIT = 5
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [PIX_BIT-1:0]                 i_pix_in,
  input  logic                               i_pix_valid,
  output logic                               o_pix_ready,
  output logic [PIX_BIT*IMG_DIM*IMG_DIM-1:0] o_img_out,
  output logic [SEL_BIT-1:0]                 o_select,
  output logic                               o_row_valid,
  input  logic                               i_row_ready,
  output logic                               o_row_last,
  output logic                               o_frame_done
);

  // state | meaning
  // IDLE  | one cycle after reset release, then LOAD
  // LOAD  | accepting pixels into (row, col); last pixel moves to SCAN
  // SCAN  | presenting rows 0..IMG_DIM-1; final row handshake returns to LOAD

  localparam int IMG_BITS = PIX_BIT * IMG_DIM * IMG_DIM;
  localparam int IDX_W    = $clog2(IMG_BITS);
  localparam logic [SEL_BIT-1:0] LAST = SEL_BIT'(IMG_DIM - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SCAN} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SEL_BIT-1:0]   r_col;
  logic [SEL_BIT-1:0]   r_row;
  logic [SEL_BIT-1:0]   r_select;
  logic [IMG_BITS-1:0]  r_img;
  logic                 r_frame_done;

  logic                 w_pix_acc;
  logic                 w_last_pix;
  logic                 w_row_acc;
  logic                 w_last_row;
  logic [IDX_W-1:0]     w_bit_base;

  assign w_pix_acc  = (r_state == ST_LOAD) && i_pix_valid;
  assign w_last_pix = w_pix_acc && (r_col == LAST) && (r_row == LAST);
  assign w_row_acc  = (r_state == ST_SCAN) && i_row_ready;
  assign w_last_row = w_row_acc && (r_select == LAST);
  assign w_bit_base = IDX_W'(r_row) * IDX_W'(PIX_BIT * IMG_DIM)
                    + IDX_W'(r_col) * IDX_W'(PIX_BIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_LOAD;
      ST_LOAD: if (w_last_pix) w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_last_row) w_state_nxt = ST_LOAD;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_select     <= '0;
      r_img        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_last_row;
      if (w_pix_acc) begin
        r_img[w_bit_base +: PIX_BIT] <= i_pix_in;
        if (r_col == LAST) begin
          r_col <= '0;
          r_row <= w_last_pix ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // Select only moves on row handshakes, so it is already 0 when SCAN starts.
      if (w_row_acc) begin
        r_select <= (r_select == LAST) ? '0 : r_select + 1'b1;
      end
    end
  end

  assign o_pix_ready  = (r_state == ST_LOAD);
  assign o_row_valid  = (r_state == ST_SCAN);
  assign o_row_last   = o_row_valid && (r_select == LAST);
  assign o_select     = r_select;
  assign o_img_out    = r_img;
  assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_image_row_loader.sv
// Randomized bench for image_row_loader: an array image model tracks the fill
// position and expected row scan, and all comparisons go through chk().
module tb_image_row_loader;

  localparam int PIX_BIT = 10;
  localparam int IMG_DIM = 28;
  localparam int SEL_BIT = 5;
  localparam int NPIX    = IMG_DIM * IMG_DIM;
  localparam int IMG_W   = PIX_BIT * NPIX;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n;
  logic [PIX_BIT-1:0]   i_pix_in;
  logic                 i_pix_valid;
  logic                 o_pix_ready;
  logic [IMG_W-1:0]     o_img_out;
  logic [SEL_BIT-1:0]   o_select;
  logic                 o_row_valid;
  logic                 i_row_ready;
  logic                 o_row_last;
  logic                 o_frame_done;

  image_row_loader #(.PIX_BIT(PIX_BIT), .IMG_DIM(IMG_DIM), .SEL_BIT(SEL_BIT)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_pix_in     (i_pix_in),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .o_img_out    (o_img_out),
    .o_select     (o_select),
    .o_row_valid  (o_row_valid),
    .i_row_ready  (i_row_ready),
    .o_row_last   (o_row_last),
    .o_frame_done (o_frame_done)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference image indexed by raster position, plus the next fill position.
  logic [PIX_BIT-1:0] ref_img [NPIX];
  int                 fill = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [IMG_W-1:0] ref_vec();
    logic [IMG_W-1:0] v;
    for (int i = 0; i < NPIX; i++) v[i*PIX_BIT +: PIX_BIT] = ref_img[i];
    return v;
  endfunction

  function automatic logic [PIX_BIT-1:0] dut_pix(input int r, input int c);
    return o_img_out[(r*IMG_DIM + c)*PIX_BIT +: PIX_BIT];
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NPIX; i++) ref_img[i] = '0;
    fill = 0;
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random. dmode: 0 raster index, 1 constant, 2 random.
  task automatic load_frame(input int vmode, input int dmode, input logic [PIX_BIT-1:0] cval,
                            input int stop_at, output int cycles);
    logic v;
    logic [PIX_BIT-1:0] d;
    int ph = 0;
    cycles = 0;
    while (fill < stop_at && cycles < 4000) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (ph % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      case (dmode)
        0:       d = PIX_BIT'(fill % 1024);
        1:       d = cval;
        default: d = PIX_BIT'($urandom);
      endcase
      ph++;
      i_pix_valid = v;
      i_pix_in    = d;
      chk("load_pix_ready", o_pix_ready, 1);
      step();
      cycles++;
      if (v) begin
        ref_img[fill] = d;
        fill++;
      end
    end
    i_pix_valid = 1'b0;
    if (cycles >= 4000) chk("load_timeout", fill, stop_at);
    if (fill == NPIX) begin
      fill = 0;
      chk("post_load_pix_ready", o_pix_ready, 0);
      chk("post_load_row_valid", o_row_valid, 1);
      chk("post_load_select", o_select, 0);
    end
    chk("load_img", o_img_out == ref_vec(), 1);
  endtask

  // smode: 0 always ready, 1 table 1,0,0,1,1 then ready, 2 random. Stops early when select hits stop_sel.
  task automatic scan_frame(input int smode, input int stop_sel, output int cycles);
    int exp_sel = 0;
    int k = 0;
    logic rdy;
    logic [4:0] pat = 5'b11001;
    cycles = 0;
    chk("scan_img_start", o_img_out == ref_vec(), 1);
    while (cycles < 500) begin
      chk("scan_row_valid", o_row_valid, 1);
      chk("scan_select", o_select, exp_sel);
      chk("scan_row_last", o_row_last, exp_sel == IMG_DIM - 1);
      chk("scan_pix_ready", o_pix_ready, 0);
      chk("scan_frame_done", o_frame_done, 0);
      if (exp_sel == stop_sel) return;
      case (smode)
        0:       rdy = 1'b1;
        1:       rdy = (k < 5) ? pat[k] : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      k++;
      i_row_ready = rdy;
      i_pix_valid = 1'($urandom_range(0, 1));
      i_pix_in    = PIX_BIT'($urandom);
      step();
      cycles++;
      i_row_ready = 1'b0;
      i_pix_valid = 1'b0;
      if (rdy) begin
        if (exp_sel == IMG_DIM - 1) begin
          chk("end_frame_done", o_frame_done, 1);
          chk("end_pix_ready", o_pix_ready, 1);
          chk("end_row_valid", o_row_valid, 0);
          chk("end_select", o_select, 0);
          chk("end_img_frozen", o_img_out == ref_vec(), 1);
          step();
          chk("frame_done_pulse", o_frame_done, 0);
          chk("after_pulse_fill", fill, 0);
          return;
        end
        exp_sel++;
      end
    end
    chk("scan_timeout", exp_sel, IMG_DIM - 1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pix_ready"}, o_pix_ready, 0);
    chk({tag, "_row_valid"}, o_row_valid, 0);
    chk({tag, "_row_last"}, o_row_last, 0);
    chk({tag, "_select"}, o_select, 0);
    chk({tag, "_frame_done"}, o_frame_done, 0);
    chk({tag, "_img_zero"}, o_img_out == '0, 1);
  endtask

  task automatic async_reset(input string tag);
    #2;
    i_rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    clear_model();
    step();
    check_reset_values({tag, "_held"});
    i_rst_n = 1'b1;
    step();
    chk({tag, "_restart_ready"}, o_pix_ready, 1);
  endtask

  initial begin
    int cyc;
    i_rst_n     = 1'b0;
    i_pix_valid = 1'b1;
    i_pix_in    = PIX_BIT'($urandom);
    i_row_ready = 1'b0;
    clear_model();

    repeat (3) step();
    check_reset_values("rst");
    i_rst_n = 1'b1;
    #1;
    chk("idle_pix_ready", o_pix_ready, 0);
    i_pix_valid = 1'b0;
    step();
    chk("startup_pix_ready", o_pix_ready, 1);
    chk("startup_row_valid", o_row_valid, 0);

    load_frame(0, 0, '0, NPIX, cyc);
    chk("full_rate_cycles", cyc, NPIX);
    chk("pix_r0c0", dut_pix(0, 0), 0);
    chk("pix_r1c0", dut_pix(1, 0), 28);
    chk("pix_r27c27", dut_pix(27, 27), 783);
    scan_frame(0, -1, cyc);
    chk("scan_full_rate_cycles", cyc, IMG_DIM);

    load_frame(1, 0, '0, NPIX, cyc);
    chk("gapped_cycles", cyc, 2*NPIX - 1);
    scan_frame(1, -1, cyc);
    chk("scan_pattern_cycles", cyc, IMG_DIM + 2);

    load_frame(2, 2, '0, NPIX, cyc);
    scan_frame(2, -1, cyc);

    load_frame(0, 1, 10'h155, NPIX, cyc);
    scan_frame(0, -1, cyc);
    load_frame(2, 1, 10'h2AA, 400, cyc);
    chk("midB_r27", dut_pix(27, 5), 10'h155);
    chk("midB_r0", dut_pix(0, 5), 10'h2AA);
    load_frame(2, 1, 10'h2AA, NPIX, cyc);
    scan_frame(2, -1, cyc);

    load_frame(0, 2, '0, 400, cyc);
    async_reset("rst_load");
    load_frame(2, 2, '0, 1, cyc);
    chk("restart_first_pix", dut_pix(0, 0), ref_img[0]);
    load_frame(2, 2, '0, NPIX, cyc);
    scan_frame(0, 13, cyc);
    async_reset("rst_scan");
    load_frame(0, 2, '0, NPIX, cyc);
    scan_frame(2, -1, cyc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
